// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-dump reader: default sizes,
// address-width derivation and the dump FSM state encoding.
package reg_dump_pkg;

  localparam int unsigned DATA_W_DEFAULT   = 16;
  localparam int unsigned NUM_REGS_DEFAULT = 8;

  // Address width needed to reach registers 0..n-1 (at least 1 bit).
  function automatic int unsigned addr_w_for(input int unsigned n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  localparam int unsigned ADDR_W_DEFAULT = addr_w_for(NUM_REGS_DEFAULT);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND,
    CSUM,
    DONE
  } state_e;

endpackage

// File: rtl/reg_dump_if.sv
// Bus bundle for the register-dump reader: control (start/busy/done),
// register-file read port and the valid/ready output stream.
interface reg_dump_if
  import reg_dump_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) ();

  logic              start;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  modport master (
    input  start,
    output rd_addr,
    input  rd_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last,
    output busy,
    output done
  );

  modport slave (
    output start,
    input  rd_addr,
    output rd_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last,
    input  busy,
    input  done
  );

endinterface

// File: rtl/reg_dump_out_stage.sv
// Output holding register for the dump stream: a load captures a word and
// raises valid; the word is held stable until valid & ready retires it.
module reg_dump_out_stage #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  // Load wins over accept so a retiring word can be replaced in one edge.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: rtl/reg_dump_reader.sv
// Register-dump reader: on start, walks registers 0..NUM_REGS-1 through the
// read port and streams each sampled value out over valid/ready.
// Optional trailing checksum word enabled by macro REG_DUMP_CHECKSUM_EN.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEFAULT,
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
  parameter int unsigned ADDR_W   = addr_w_for(NUM_REGS)
) (
  input  logic       clk,
  input  logic       rst,
  reg_dump_if.master bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              os_valid;
  logic [DATA_W-1:0] os_data;
  logic              os_last;
  logic              accept;
  logic              last_reg;
  logic              busy;
  logic              done;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  assign accept   = os_valid && bus.out_ready;
  assign last_reg = (rd_addr_q == ADDR_W'(NUM_REGS - 1));

  reg_dump_out_stage #(.DATA_W(DATA_W)) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_last (load_last),
    .ready     (bus.out_ready),
    .out_valid (os_valid),
    .out_data  (os_data),
    .out_last  (os_last)
  );

  // Dump sequencing: next state, address advance, output-stage loads.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    load      = 1'b0;
    load_data = bus.rd_data;
    load_last = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        busy      = 1'b0;
        rd_addr_d = '0;
        if (bus.start) begin
          state_d = READ;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      READ: begin
        load    = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_d  = csum_q + bus.rd_data;
`else
        load_last = last_reg;
`endif
        state_d = SEND;
      end
      SEND: begin
        if (accept) begin
          if (last_reg) begin
`ifdef REG_DUMP_CHECKSUM_EN
            // Checksum word replaces the retiring last register word directly.
            state_d   = CSUM;
            load      = 1'b1;
            load_data = csum_q;
            load_last = 1'b1;
`else
            state_d = DONE;
`endif
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
            state_d   = READ;
          end
        end
      end
      CSUM: begin
`ifdef REG_DUMP_CHECKSUM_EN
        if (accept) state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        rd_addr_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, address and checksum registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign bus.rd_addr   = rd_addr_q;
  assign bus.out_valid = os_valid;
  assign bus.out_data  = os_data;
  assign bus.out_last  = os_last;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule
